// File: rtl/sreg_deserializer.sv
// ---------------------------------------------------------------------------
// sreg_deserializer
//
// Parametrised serial-to-parallel marshaller. Collects qualified serial bits
// into WIDTH-bit words, optionally aligned by a sync marker, and presents
// each finished word on a valid/ready output register. A finished word that
// cannot be handed over (output still occupied and not accepted) is dropped
// and the sticky overflow flag is raised.
//
// Parameters:
//   WIDTH         data bits per word (2..64)
//   LSB_FIRST     1: first received bit -> word_data[0]
//                 0: first received bit -> word_data[WIDTH-1]
//   SYNC_REQUIRED 1: discard bits after reset until the first sync
//                 0: start assembling immediately after reset
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   bit_valid   serial_in / sync carry a bit this cycle
//   serial_in   serial data bit
//   sync        current bit is bit 0 of a new word (qualified by bit_valid)
//   word_data   assembled word, stable while word_valid=1
//   word_valid  word_data holds an unconsumed word
//   word_ready  downstream accepts when word_valid & word_ready
//   overflow    sticky: a completed word was dropped
//   ovf_clr     clears overflow (a simultaneous new drop wins)
//   parity_err  (SREG_DESER_PARITY_EN only) even-parity check of the word
//
// Optional feature, macro SREG_DESER_PARITY_EN: every word is followed by one
// even-parity bit; parity_err is loaded together with word_data.
// ---------------------------------------------------------------------------
module sreg_deserializer #(
  parameter int WIDTH         = 8,
  parameter int LSB_FIRST     = 1,
  parameter int SYNC_REQUIRED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             sync,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  input  logic             ovf_clr
`ifdef SREG_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  // Bit position (count value) of the final bit of a frame.
`ifdef SREG_DESER_PARITY_EN
  localparam int LAST_IDX = WIDTH;
`else
  localparam int LAST_IDX = WIDTH - 1;
`endif
  localparam int CNT_W = $clog2(LAST_IDX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_IDX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_HUNT,
    ST_ASSEMBLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_data_q, word_data_d;
  logic             word_valid_q, word_valid_d;
  logic             overflow_q, overflow_d;
`ifdef SREG_DESER_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  // Assembler helper values.
  logic [WIDTH-1:0] shifted;    // shift register with serial_in shifted in
  logic [WIDTH-1:0] seed;       // fresh register holding only serial_in as bit 0
  logic [WIDTH-1:0] done_word;  // word delivered on completion
  logic             word_done;  // a frame completes this cycle
  logic             drop;       // completed word cannot be delivered
`ifdef SREG_DESER_PARITY_EN
  logic             done_perr;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    word_done   = 1'b0;
    shifted     = '0;
    seed        = '0;
    done_word   = '0;
`ifdef SREG_DESER_PARITY_EN
    done_perr   = 1'b0;
`endif

    // LSB-first shifts right so the first bit migrates down to bit 0;
    // MSB-first shifts left so the first bit ends at the top.
    if (LSB_FIRST != 0) begin
      shifted = {serial_in, shreg_q[WIDTH-1:1]};
      seed    = {serial_in, {(WIDTH-1){1'b0}}};
    end else begin
      shifted = {shreg_q[WIDTH-2:0], serial_in};
      seed    = {{(WIDTH-1){1'b0}}, serial_in};
    end

    if (bit_valid) begin
      if (sync) begin
        // Realign: any partial word (including one missing only its last
        // bit) is discarded silently and this bit becomes bit 0.
        shreg_d = seed;
        cnt_d   = CNT_ONE;
        state_d = ST_ASSEMBLE;
      end else if (state_q == ST_ASSEMBLE) begin
        if (cnt_q == CNT_LAST) begin
          word_done = 1'b1;
          cnt_d     = '0;
          shreg_d   = '0;
`ifdef SREG_DESER_PARITY_EN
          // Final bit is the parity bit: data already sits in shreg_q.
          done_word = shreg_q;
          done_perr = (^shreg_q) ^ serial_in;
`else
          // The completed word includes the bit arriving now.
          done_word = shifted;
`endif
        end else begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
    end
  end

  // Output register and handshake.
  always_comb begin
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
`ifdef SREG_DESER_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    drop = word_done & word_valid_q & ~word_ready;

    if (word_done && !drop) begin
      // Either the register is empty or its word leaves this cycle, so the
      // new word can be loaded back-to-back without loss.
      word_data_d  = done_word;
      word_valid_d = 1'b1;
`ifdef SREG_DESER_PARITY_EN
      parity_err_d = done_perr;
`endif
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    // A new drop takes priority over a clear in the same cycle.
    overflow_d = drop | (overflow_q & ~ovf_clr);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (SYNC_REQUIRED != 0) begin
        state_q <= ST_HUNT;
      end else begin
        state_q <= ST_ASSEMBLE;
      end
      cnt_q        <= '0;
      shreg_q      <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef SREG_DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
`ifdef SREG_DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign overflow   = overflow_q;
`ifdef SREG_DESER_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sreg_deserializer.sv
// ---------------------------------------------------------------------------
// tb_sreg_deserializer
//
// Drives two deserializers (LSB-first and MSB-first, WIDTH=8, sync required)
// from the same serial stream and compares every cycle against a bit-queue
// reference model: bits since the last sync are collected in a queue and a
// word is formed when the queue holds a full frame. Directed scenarios are
// followed by a long random phase.
// ---------------------------------------------------------------------------
module tb_sreg_deserializer;

  localparam int W = 8;
`ifdef SREG_DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_valid = 1'b0;
  logic         serial_in = 1'b0;
  logic         sync = 1'b0;
  logic         word_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] wd_l, wd_m;
  logic         wv_l, wv_m, ov_l, ov_m;
`ifdef SREG_DESER_PARITY_EN
  logic         pe_l, pe_m;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sreg_deserializer #(.WIDTH(W), .LSB_FIRST(1), .SYNC_REQUIRED(1)) dut_lsb (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .serial_in(serial_in),
    .sync(sync), .word_data(wd_l), .word_valid(wv_l), .word_ready(word_ready),
    .overflow(ov_l), .ovf_clr(ovf_clr)
`ifdef SREG_DESER_PARITY_EN
    , .parity_err(pe_l)
`endif
  );

  sreg_deserializer #(.WIDTH(W), .LSB_FIRST(0), .SYNC_REQUIRED(1)) dut_msb (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .serial_in(serial_in),
    .sync(sync), .word_data(wd_m), .word_valid(wv_m), .word_ready(word_ready),
    .overflow(ov_m), .ovf_clr(ovf_clr)
`ifdef SREG_DESER_PARITY_EN
    , .parity_err(pe_m)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_hunting = 1'b1;
  bit           m_bits[$];
  bit           m_valid = 1'b0;
  bit           m_ovf = 1'b0;
  logic [W-1:0] m_dl = '0;
  logic [W-1:0] m_dm = '0;
  bit           m_perr = 1'b0;

  // Applies the inputs present at this clock edge to the model.
  task automatic model_step();
    bit           done = 1'b0;
    bit           drop;
    logic [W-1:0] wl = '0;
    logic [W-1:0] wm = '0;
    bit           perr = 1'b0;
    if (rst) begin
      m_hunting = 1'b1;
      m_bits.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_dl    = '0;
      m_dm    = '0;
      m_perr  = 1'b0;
      return;
    end
    if (bit_valid) begin
      if (sync) begin
        m_bits.delete();
        m_bits.push_back(serial_in);
        m_hunting = 1'b0;
      end else if (!m_hunting) begin
        m_bits.push_back(serial_in);
        if (m_bits.size() == FRAME) begin
          done = 1'b1;
          for (int i = 0; i < W; i++) begin
            wl[i]       = m_bits[i];
            wm[W-1-i]   = m_bits[i];
          end
          for (int i = 0; i < FRAME; i++) perr ^= m_bits[i];
          m_bits.delete();
        end
      end
    end
    drop = done && m_valid && !word_ready;
    if (done && !drop) begin
      m_valid = 1'b1;
      m_dl    = wl;
      m_dm    = wm;
      m_perr  = perr;
    end else if (m_valid && word_ready) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    check("valid_lsb", wv_l, m_valid);
    check("valid_msb", wv_m, m_valid);
    check("data_lsb", wd_l, m_dl);
    check("data_msb", wd_m, m_dm);
    check("ovf_lsb", ov_l, m_ovf);
    check("ovf_msb", ov_m, m_ovf);
`ifdef SREG_DESER_PARITY_EN
    check("perr_lsb", pe_l, m_perr);
    check("perr_msb", pe_m, m_perr);
`endif
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input bit bv, input bit si, input bit sy, input bit rdy,
                      input bit clr, input bit r);
    bit_valid  = bv;
    serial_in  = si;
    sync       = sy;
    word_ready = rdy;
    ovf_clr    = clr;
    rst        = r;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Sends a synced word, first bit = w[0]; pflip corrupts the parity bit.
  task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit pflip);
    for (int i = 0; i < W; i++) step(1'b1, w[i], i == 0, rdy, 1'b0, 1'b0);
`ifdef SREG_DESER_PARITY_EN
    step(1'b1, (^w) ^ pflip, 1'b0, rdy, 1'b0, 1'b0);
`else
    if (pflip) $display("note: parity flip ignored in this build");
`endif
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", wv_l, 1'b0);
    check("rst_data", wd_l, 8'h00);
    check("rst_ovf", ov_l, 1'b0);

    // Bits before the first sync are ignored, then one word 0xA5.
    for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0, 1'b1, 1'b0, 1'b0);
    check("hunt_no_word", wv_l, 1'b0);
    send_word(8'hA5, 1'b1, 1'b0);
    check("hunt_valid", wv_l, 1'b1);
    check("hunt_data", wd_l, 8'hA5);
    idle(1'b1);
    check("hunt_single", wv_l, 1'b0);

    // Stream 1,0,1,1,0,0,1,0 -> 0x4D LSB-first, 0xB2 MSB-first, 1-cycle pulse.
    send_word(8'h4D, 1'b1, 1'b0);
    check("ord_valid", wv_l, 1'b1);
    check("ord_lsb", wd_l, 8'h4D);
    check("ord_msb", wd_m, 8'hB2);
    idle(1'b1);
    check("ord_pulse", wv_l, 1'b0);
    check("ord_hold", wd_l, 8'h4D);

    // Back-pressure: 0x11 held, 0x22 dropped, overflow set then cleared.
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    check("ovf_keep", wd_l, 8'h11);
    check("ovf_set", ov_l, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovf_clr", ov_l, 1'b0);

    // Realign after 3 bits: only 0x3C appears, no overflow.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("realign_none", wv_l, 1'b0);
    send_word(8'h3C, 1'b1, 1'b0);
    check("realign_data", wd_l, 8'h3C);
    check("realign_ovf", ov_l, 1'b0);
    idle(1'b1);

    // Sync on the last bit position still realigns.
    for (int i = 0; i < FRAME - 1; i++) step(1'b1, 1'b1, i == 0, 1'b1, 1'b0, 1'b0);
    send_word(8'h96, 1'b1, 1'b0);
    check("late_sync", wd_l, 8'h96);
    idle(1'b1);

    // Reset mid-word with a pending output word.
    send_word(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", wv_l, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_mid_valid", wv_l, 1'b0);
    check("rst_mid_data", wd_l, 8'h00);
    check("rst_mid_ovf", ov_l, 1'b0);
    send_word(8'hFF, 1'b1, 1'b0);
    check("post_rst_data", wd_l, 8'hFF);
    idle(1'b1);

`ifdef SREG_DESER_PARITY_EN
    send_word(8'h07, 1'b1, 1'b0);
    check("par_ok", pe_l, 1'b0);
    send_word(8'h07, 1'b1, 1'b1);
    check("par_bad", pe_l, 1'b1);
    idle(1'b1);
`endif

    // Random phase.
    for (int n = 0; n < 4000; n++) begin
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 599) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sreg_deserializer.md
Name: sreg_deserializer

Overview:
- Parametrised serial-to-parallel marshaller; successor to the fixed 8-bit shift-register marshaller.
- Assembles WIDTH-bit words from a qualified serial bit stream.
- Provides frame alignment via a sync input, LSB- or MSB-first ordering, and a valid/ready output handshake with overflow detection.
- Sits between a serial link front-end and word-oriented downstream logic.

Parameters:
- WIDTH, 8: data bits per word; legal range 2..64.
- LSB_FIRST, 1: 1 = first received bit lands in word_data[0]; 0 = first bit lands in word_data[WIDTH-1].
- SYNC_REQUIRED, 1: 1 = after reset, discard bits until the first sync; 0 = start assembling immediately.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- bit_valid, input, 1: serial_in carries a valid bit this cycle.
- serial_in, input, 1: serial data bit.
- sync, input, 1: qualified by bit_valid; marks the current bit as bit 0 of a new word.
- word_data, output, WIDTH: assembled word, held stable while word_valid=1.
- word_valid, output, 1: word_data is valid.
- word_ready, input, 1: downstream accepts; transfer occurs when word_valid & word_ready.
- overflow, output, 1: sticky; a completed word was dropped.
- ovf_clr, input, 1: clears overflow.

Behaviour:
- Reset (synchronous, active-high):
  - word_data=0, word_valid=0, overflow=0, shift register=0, bit count=0.
  - State = HUNT if SYNC_REQUIRED=1, else ASSEMBLE.
- Reset asserted mid-word discards the partial word and any pending output word.
- States:
  - HUNT: ignore bits without sync. On bit_valid & sync, store the bit as bit 0, set count=1, go to ASSEMBLE.
  - ASSEMBLE: on each bit_valid, shift in serial_in and increment count.
- Sync inside ASSEMBLE:
  - The partial word is discarded silently, with no overflow.
  - The bit is stored as bit 0 and count is set to 1.
  - A sync bit that arrives exactly when count=WIDTH-1 still realigns; the partial word is not emitted.
- Ordering:
  - LSB_FIRST=1: shift right, new bit enters the MSB; after WIDTH bits, the first bit sits at bit 0.
  - LSB_FIRST=0: shift left, new bit enters the LSB.
- Word completion: bit_valid with count=WIDTH-1 and no sync.
  - The completed word includes the current bit; the off-by-one of the previous generation is not reproduced.
  - Count wraps to 0 and the state stays ASSEMBLE.
- Latency: word_valid rises on the clock edge after the final bit is sampled (1 cycle).
- Output register behaviour on completion:
  - word_valid=0, or word_valid=1 with word_ready=1 in the same cycle: load the new word, word_valid=1. This is back-to-back, lossless.
  - word_valid=1 with word_ready=0: keep the old word, drop the new one, set overflow=1.
- word_valid & word_ready with no completion: word_valid=0 next cycle; word_data holds its last value.
- While word_valid=1, word_data must not change unless a new word is loaded per the rules above.
- bit_valid=0: no state change in the assembler; the handshake still operates.
- ovf_clr and a new overflow in the same cycle: overflow stays 1 (set wins).
- Throughput: one bit per cycle sustained; minimum word period WIDTH cycles.

Optional Feature:
- Macro: SREG_DESER_PARITY_EN.
- When defined:
  - Each word is WIDTH data bits followed by one even-parity bit; count runs 0..WIDTH.
  - Added output parity_err (1 bit, reset 0). It is loaded alongside word_data and is 1 when the XOR of the data bits and the parity bit is 1.
  - A sync on the parity-bit position realigns exactly as in ASSEMBLE.
- When undefined:
  - No parity bit and no parity_err port; words are exactly WIDTH bits.

Test Plan:
- WIDTH=8, LSB_FIRST=1: sync on the first bit, stream bits 1,0,1,1,0,0,1,0 with word_ready=1 -> word_data=8'h4D and word_valid high for 1 cycle, one cycle after the 8th bit.
- Same bit stream with LSB_FIRST=0 -> word_data=8'hB2.
- SYNC_REQUIRED=1: 5 bits without sync, then sync plus 8 bits encoding 8'hA5 -> the first 5 bits are ignored; exactly one word, 8'hA5.
- Hold word_ready=0; send 8'h11 then 8'h22 -> word_data stays 8'h11, overflow=1. Then ovf_clr=1 -> overflow=0 next cycle.
- Sync after 3 bits of a word, then 8 bits of 8'h3C -> the only word output is 8'h3C; overflow=0.
- Assert rst after 4 bits, with word_valid=1 -> next cycle all outputs are 0; the following synced 8 bits of 8'hFF -> 8'hFF.
- With SREG_DESER_PARITY_EN: 8'h07 followed by parity bit 1 -> parity_err=0; same data with parity bit 0 -> parity_err=1.
